// File: rtl/gt_max_scan_ctrl.sv
// gt_max_scan_ctrl
// Scans an N-entry file of 2-bit operands using one external 2-bit
// greater-than comparator. It returns the maximum value and the lowest index
// that holds that value.
// Optional macro GT_SCAN_REG_CMP_EN: the comparator result is registered.
// Each comparison then takes two cycles: one to present the operands and one
// to update the result. The functional result is the same either way.
module gt_max_scan_ctrl #(
  parameter int N  = 4,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [1:0]    max_val,
  output logic [IW-1:0] max_idx,
  output logic [1:0]    cmp_a,
  output logic [1:0]    cmp_b,
  input  logic          cmp_agtb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mem_q [N];
  logic [N-1:0]  wr_sel;
  logic [1:0]    rd_val;
  logic [1:0]    best_val_q, best_val_d;
  logic [IW-1:0] best_idx_q, best_idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [1:0]    max_val_q;
  logic [IW-1:0] max_idx_q;
  logic          last_ptr;
  logic          step_update;
  logic          take_new;

  // Writes are accepted only while idle. The address decode is done on the
  // full address width, so any address at or above N selects no entry.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && !busy && (wr_addr == IW'(gi));
    end
  endgenerate

  // Operand file registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_sel[i]) mem_q[i] <= wr_data;
      end
    end
  end

  // Read mux selecting the entry under the scan pointer.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr_q == IW'(i)) rd_val = mem_q[i];
    end
  end

  assign last_ptr = (ptr_q == IW'(N - 1));

`ifdef GT_SCAN_REG_CMP_EN
  logic phase_q, phase_d;
  logic agtb_q;

  // Compare phase: capture the comparator result, then update on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      agtb_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (state_q == ST_SCAN && !phase_q) agtb_q <= cmp_agtb;
    end
  end

  // Phase toggles on every scan cycle and is cleared when a scan starts.
  always_comb begin
    phase_d = phase_q;
    if (state_q == ST_IDLE && start) phase_d = 1'b0;
    else if (state_q == ST_SCAN)     phase_d = ~phase_q;
  end

  assign step_update = phase_q;
  assign take_new    = agtb_q;
`else
  assign step_update = 1'b1;
  assign take_new    = cmp_agtb;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. A start pulse outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SCAN;
      ST_SCAN: if (step_update && last_ptr) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state. The comparator inputs are held at zero outside SCAN.
  always_comb begin
    busy  = (state_q != ST_IDLE);
    done  = (state_q == ST_DONE);
    cmp_a = '0;
    cmp_b = '0;
    if (state_q == ST_SCAN) begin
      cmp_a = rd_val;
      cmp_b = best_val_q;
    end
  end

  // Scan datapath. The strict greater-than comparison keeps the earliest
  // index when two entries tie. Entry 0 is sampled before any write made in
  // the same cycle as start.
  always_comb begin
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    ptr_d      = ptr_q;
    if (state_q == ST_IDLE && start) begin
      best_val_d = mem_q[0];
      best_idx_d = '0;
      ptr_d      = IW'(1);
    end else if (state_q == ST_SCAN && step_update) begin
      if (take_new) begin
        best_val_d = rd_val;
        best_idx_d = ptr_q;
      end
      if (!last_ptr) ptr_d = ptr_q + IW'(1);
    end
  end

  // Scan working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_val_q <= '0;
      best_idx_q <= '0;
      ptr_q      <= '0;
    end else begin
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      ptr_q      <= ptr_d;
    end
  end

  // Result registers. They are updated only when leaving DONE and hold their
  // value otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else if (state_q == ST_DONE) begin
      max_val_q <= best_val_q;
      max_idx_q <= best_idx_q;
    end
  end

  assign max_val = max_val_q;
  assign max_idx = max_idx_q;

endmodule

// File: tb/tb_gt_max_scan_ctrl.sv
// Directed testbench for gt_max_scan_ctrl (N=4). It models the external
// gt_2bit comparator inline.
module tb_gt_max_scan_ctrl;
  localparam int N  = 4;
  localparam int IW = 4;
`ifdef GT_SCAN_REG_CMP_EN
  localparam int LAT = 2 * (N - 1) + 1;
`else
  localparam int LAT = N;
`endif

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [1:0]    wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic [1:0]    max_val;
  logic [IW-1:0] max_idx;
  logic [1:0]    cmp_a;
  logic [1:0]    cmp_b;
  logic          cmp_agtb;

  int errors = 0;
  int checks = 0;
  logic [1:0]    last_val = '0;
  logic [IW-1:0] last_idx = '0;

  gt_max_scan_ctrl #(.N(N), .IW(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .max_val  (max_val),
    .max_idx  (max_idx),
    .cmp_a    (cmp_a),
    .cmp_b    (cmp_b),
    .cmp_agtb (cmp_agtb)
  );

  assign cmp_agtb = (cmp_a > cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [7:0]    ops;   // {e3, e2, e1, e0}
    logic [1:0]    ev;
    logic [IW-1:0] ei;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic write_entry(input logic [IW-1:0] a, input logic [1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [7:0] ops);
    for (int i = 0; i < N; i++) write_entry(IW'(i), ops[2*i +: 2]);
  endtask

  // ops holds the operand file as seen at the start edge; entry 0 is the pre-write value.
  task automatic run_scan(input string nm, input logic [7:0] ops, input logic [1:0] ev,
                          input logic [IW-1:0] ei, input bit disturb, input bit same_wr);
    int n;
    bit got;
    start = 1'b1;
    if (same_wr) begin wr_en = 1'b1; wr_addr = '0; wr_data = 2'd3; end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check({nm, " cmp_a first"}, 32'(cmp_a), 32'(ops[3:2]));
        check({nm, " cmp_b first"}, 32'(cmp_b), 32'(ops[1:0]));
      end
      check({nm, " busy in scan"}, 32'(busy), 32'd1);
      if (done) got = 1'b1;
      else begin
        check({nm, " max_val held"}, 32'(max_val), 32'(last_val));
        check({nm, " max_idx held"}, 32'(max_idx), 32'(last_idx));
      end
      if (disturb && n == 2) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 2'd3;
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
      end
    end
    check({nm, " done seen"}, 32'(got), 32'd1);
    check({nm, " latency"}, 32'(n), 32'(LAT));
    @(posedge clk); #1;
    check({nm, " busy after"}, 32'(busy), 32'd0);
    check({nm, " done after"}, 32'(done), 32'd0);
    check({nm, " max_val"}, 32'(max_val), 32'(ev));
    check({nm, " max_idx"}, 32'(max_idx), 32'(ei));
    check({nm, " cmp_a idle"}, 32'(cmp_a), 32'd0);
    check({nm, " cmp_b idle"}, 32'(cmp_b), 32'd0);
    last_val = ev; last_idx = ei;
    repeat (3) begin
      @(negedge clk);
      check({nm, " no extra done"}, 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    $display("scan %s: max_val=%0d max_idx=%0d latency=%0d", nm, max_val, max_idx, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_done;
    vecs[0] = '{"v1320", {2'd0, 2'd2, 2'd3, 2'd1}, 2'd3, 4'd1};
    vecs[1] = '{"tie2212", {2'd2, 2'd1, 2'd2, 2'd2}, 2'd2, 4'd0};
    vecs[2] = '{"zeros", 8'h00, 2'd0, 4'd0};
    vecs[3] = '{"last0003", {2'd3, 2'd0, 2'd0, 2'd0}, 2'd3, 4'd3};
    vecs[4] = '{"all3", 8'hFF, 2'd3, 4'd0};
    vecs[5] = '{"ramp0123", {2'd3, 2'd2, 2'd1, 2'd0}, 2'd3, 4'd3};
    vecs[6] = '{"v1001", {2'd1, 2'd0, 2'd0, 2'd1}, 2'd1, 4'd0};
    vecs[7] = '{"v0212", {2'd2, 2'd1, 2'd2, 2'd0}, 2'd2, 4'd1};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset max_val", 32'(max_val), 32'd0);
    check("reset max_idx", 32'(max_idx), 32'd0);
    check("reset cmp_a", 32'(cmp_a), 32'd0);
    check("reset cmp_b", 32'(cmp_b), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      load(vecs[v].ops);
      run_scan(vecs[v].name, vecs[v].ops, vecs[v].ev, vecs[v].ei, 1'b0, 1'b0);
    end

    // Out-of-range addresses must not alias onto real entries.
    load({2'd0, 2'd0, 2'd1, 2'd0});
    write_entry(4'd4, 2'd3);
    write_entry(4'd15, 2'd3);
    run_scan("oob_write", {2'd0, 2'd0, 2'd1, 2'd0}, 2'd1, 4'd1, 1'b0, 1'b0);

    // Start and write to entry 0 in the same cycle: the scan uses the old entry 0.
    load({2'd0, 2'd0, 2'd0, 2'd1});
    run_scan("same_cycle", {2'd0, 2'd0, 2'd0, 2'd1}, 2'd1, 4'd0, 1'b0, 1'b1);
    run_scan("after_same", {2'd0, 2'd0, 2'd0, 2'd3}, 2'd3, 4'd0, 1'b0, 1'b0);

    // Start and a write during a scan are both ignored.
    load({2'd0, 2'd2, 2'd3, 2'd1});
    run_scan("disturb", {2'd0, 2'd2, 2'd3, 2'd1}, 2'd3, 4'd1, 1'b1, 1'b0);
    run_scan("post_disturb", {2'd0, 2'd2, 2'd3, 2'd1}, 2'd3, 4'd1, 1'b0, 1'b0);

    // Reset in the middle of a scan.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst max_val", 32'(max_val), 32'd0);
    check("midrst max_idx", 32'(max_idx), 32'd0);
    check("midrst cmp_a", 32'(cmp_a), 32'd0);
    check("midrst cmp_b", 32'(cmp_b), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midrst no done", 32'(saw_done), 32'd0);
    $display("midscan reset: busy=%0d max_val=%0d max_idx=%0d", busy, max_val, max_idx);
    last_val = '0; last_idx = '0;
    @(posedge clk); #1;
    load({2'd1, 2'd3, 2'd0, 2'd2});
    run_scan("after_reset", {2'd1, 2'd3, 2'd0, 2'd2}, 2'd3, 4'd2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gt_max_scan_ctrl.md
# gt_max_scan_ctrl

- Sequences one shared 2-bit greater-than comparator (`gt_2bit`, instantiated beside this block) over a small register file of 2-bit operands.
- Returns the maximum value and the index where it first occurs.
- Sits between the Basys3 switch/button input logic, which loads operands and pulses `start`, and the display logic, which reads `max_val`/`max_idx` after `done`.
- Uses exactly one comparator, so each scan step makes one comparison.

## Interface
Parameters:
- `N`, 4: number of operand entries; legal range 2..16.
- `IW`, 4: index width; must satisfy 2^IW >= N.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe for the operand file.
- `wr_addr`  in  IW  entry to write; values >= N are ignored.
- `wr_data`  in  2  operand value.
- `start`  in  1  single-cycle pulse that begins a scan.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse when the result is valid.
- `max_val`  out  2  maximum operand found.
- `max_idx`  out  IW  lowest index that holds `max_val`.
- `cmp_a`  out  2  drives the comparator `a` input.
- `cmp_b`  out  2  drives the comparator `b` input.
- `cmp_agtb`  in  1  comparator result (a > b), purely combinational from `cmp_a`/`cmp_b`.

## Operation
- Operand file: N x 2-bit registers.
  - Written on a `clk` edge when `wr_en` is high, `busy` is low, and `wr_addr` < N.
  - Writes while `busy` is high are dropped.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On `start`: load `best_val` <= mem[0], `best_idx` <= 0, `ptr` <= 1.
  - Go to SCAN and set `busy` high.
- SCAN:
  - `cmp_a` = mem[`ptr`], `cmp_b` = `best_val`, both combinational from the registers.
  - If `cmp_agtb` = 1: `best_val` <= mem[`ptr`], `best_idx` <= `ptr`.
  - Comparison is strict, so ties keep the earlier index.
  - If `ptr` = N-1: go to DONE. Otherwise `ptr` <= `ptr` + 1.
- DONE:
  - Register `max_val` <= `best_val`, `max_idx` <= `best_idx`.
  - `done` = 1 for this cycle; `busy` drops; return to IDLE.
- In IDLE and DONE, `cmp_a` = `cmp_b` = 0.
- `start` while `busy` is high is ignored (no queuing, no restart).
- `max_val`/`max_idx` hold their last result until the next DONE.
- Outputs change only on DONE, never mid-scan.
- `start` and `wr_en` in the same IDLE cycle:
  - The write lands on that edge.
  - The scan reads mem[0] before that write. If `wr_addr` = 0, the scan therefore uses the old mem[0].
  - Later entries are read after the write.
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - All operand registers, `best_*`, `ptr`, `max_val`, `max_idx` clear to 0.
  - `busy` = 0, `done` = 0, `cmp_a` = `cmp_b` = 0.
  - Reset mid-scan abandons the scan and no `done` is produced.

## Timing
- `start` sampled at edge k.
- `busy` is high from after edge k until edge k+N.
- Comparisons are made in cycles k+1 .. k+N-1, N-1 in total.
- `done` is high in the cycle after edge k+N-1 (state DONE); `max_*` update at edge k+N, coincident with `done` falling.
- Scan latency, `start` to `done`: N cycles.
- The earliest accepted `start` after DONE is the cycle after `done`.
- The comparator path `mem` -> `cmp_a`/`cmp_b` -> `cmp_agtb` -> `best_*` is single-cycle combinational.

## Configuration
- `GT_SCAN_REG_CMP_EN`
  - Defined: `cmp_agtb` is captured in a flop, and each comparison takes two cycles (present operands, then update).
  - With the macro defined, `start` to `done` latency is 2(N-1)+1 cycles, and `busy` stays high for that whole window.
  - Undefined: single-cycle compare as described above, latency N.
  - Functional results are identical either way.

## Test plan
- N=4, write [1,3,2,0], pulse `start` at edge k -> `done` at k+4, `max_val`=3, `max_idx`=1, `busy` high for 4 cycles.
- Write [2,2,1,2], `start` -> `max_val`=2, `max_idx`=0 (tie keeps the lowest index).
- All entries 0 -> `max_val`=0, `max_idx`=0. Then write [0,0,0,3] and `start` -> `max_val`=3, `max_idx`=3 (last-entry boundary).
- During a scan:
  - Pulse `start` again and write entry 0 <= 3.
  - Required: no restart, no extra `done`, result unchanged.
  - A following scan still sees the old entry 0.
- Assert `rst_n` low at cycle k+2 of a scan:
  - `busy`, `done`, `max_*`, `cmp_*` go to 0 immediately.
  - No `done` follows.
  - A fresh load and scan works normally.
- With `GT_SCAN_REG_CMP_EN`, [1,3,2,0] -> `done` 7 cycles after `start`, `max_val`=3, `max_idx`=1.
